// File: rtl/hash_request_tx_pkg.sv
// Shared types and field-offset helpers for the hash request stream.
package hash_stream_pkg;

  localparam int OP_WIDTH = 2;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef enum logic {
    FLUSH_IDLE    = 1'b0,
    FLUSH_PENDING = 1'b1
  } flush_state_t;

  typedef struct packed {
    flush_state_t flush;
    skid_state_t  skid;
  } dbg_t;

  function automatic int key_lsb();
    return 0;
  endfunction

  function automatic int value_lsb(input int key_width);
    return key_width;
  endfunction

  function automatic int op_msb(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/hash_request_tx_if.sv
// Command-side and stream-side bundles of the hash request transmitter.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// the sender holds valid and payload stable until that transfer.
interface hash_cmd_if #(
  parameter int KEY_WIDTH   = 14,
  parameter int VALUE_WIDTH = 16
);
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [1:0]             cmd_op_i;
  logic [KEY_WIDTH-1:0]   cmd_key_i;
  logic [VALUE_WIDTH-1:0] cmd_value_i;
  logic                   cmd_last_i;
  logic                   flush_i;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_key_i, cmd_value_i, cmd_last_i, flush_i,
    input  cmd_ready_o
  );
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_key_i, cmd_value_i, cmd_last_i, flush_i,
    output cmd_ready_o
  );
endinterface

interface hash_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  last_o;
  logic                  ready_i;

  modport master (
    output data_o, valid_o, last_o,
    input  ready_i
  );
  modport slave (
    input  data_o, valid_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/hash_request_tx_skid.sv
// Two-entry skid buffer: output register plus one overflow register, with a
// registered input ready so upstream never sees a combinational path from out_ready.
module stream_skid_buffer
  import hash_stream_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output skid_state_t  state
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] skid_q;
  logic         enq, deq;
  logic         load_out, load_skid, skid_to_out;

  assign out_valid = (state_q != EMPTY);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign state     = state_q;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: begin
        if (enq) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (enq && deq) begin
          load_out = 1'b1;
        end else if (enq) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a dequeue can happen
        if (deq) begin
          state_d     = ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
      if (load_out) begin
        out_data <= in_data;
      end else if (skid_to_out) begin
        out_data <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/hash_request_tx.sv
// Packs (op, key, value) commands into stream beats, closes batches with last
// (explicit, forced at MAX_BATCH, or by flush) and counts transferred commands.
module hash_request_tx
  import hash_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEY_WIDTH   = 14,
  parameter int VALUE_WIDTH = 16,
  parameter int MAX_BATCH   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hash_cmd_if.slave            cmd,
  hash_stream_if.master        stream,
  output logic [CNT_WIDTH-1:0] sent_count_o,
  output dbg_t                 dbg
);

  localparam int BW = (MAX_BATCH > 1) ? $clog2(MAX_BATCH) : 1;

  if (KEY_WIDTH + VALUE_WIDTH != DATA_WIDTH - OP_WIDTH) begin : g_bad_widths
    $error("hash_request_tx: KEY_WIDTH + VALUE_WIDTH must equal DATA_WIDTH - 2");
  end
  if (MAX_BATCH < 1) begin : g_bad_batch
    $error("hash_request_tx: MAX_BATCH must be at least 1");
  end

  op_t                   cmd_op;
  logic                  cmd_fire, is_nop, beat_enq, nop_enq;
  logic                  flush_req, batch_full, beat_last;
  logic [BW-1:0]         batch_cnt;
  logic [DATA_WIDTH-1:0] packed_beat;
  flush_state_t          flush_q, flush_d;
  logic                  skid_ready, skid_in_valid;
  logic [DATA_WIDTH:0]   skid_in_data, out_beat;
  skid_state_t           skid_state;

  assign cmd_op     = op_t'(cmd.cmd_op_i);
  assign cmd_fire   = cmd.cmd_valid_i && cmd.cmd_ready_o;
  assign is_nop     = (cmd_op == OP_NOP);
  assign beat_enq   = cmd_fire && !is_nop;
  // A NOP carrying last has nothing to close a batch with, so it acts as a flush
  assign flush_req  = cmd.flush_i || (cmd_fire && is_nop && cmd.cmd_last_i);
  assign batch_full = (batch_cnt == BW'(MAX_BATCH - 1));
  assign beat_last  = cmd.cmd_last_i || cmd.flush_i || batch_full;
  assign nop_enq    = (flush_q == FLUSH_PENDING) && skid_ready;

  // Holding ready low while a flush is pending keeps the closing NOP ahead of new work
  assign cmd.cmd_ready_o = skid_ready && (flush_q == FLUSH_IDLE);

  always_comb begin
    packed_beat = '0;
    packed_beat[op_msb(DATA_WIDTH) -: OP_WIDTH] = cmd_op;
    if (cmd_op == OP_WRITE) begin
      packed_beat[value_lsb(KEY_WIDTH) +: VALUE_WIDTH] = cmd.cmd_value_i;
    end
    packed_beat[key_lsb() +: KEY_WIDTH] = cmd.cmd_key_i;
  end

  assign skid_in_valid = beat_enq || nop_enq;
  assign skid_in_data  = nop_enq ? {1'b1, {DATA_WIDTH{1'b0}}} : {beat_last, packed_beat};

  always_comb begin
    flush_d = flush_q;
    case (flush_q)
      FLUSH_IDLE: begin
        if (flush_req && !beat_enq && (batch_cnt != '0)) begin
          flush_d = FLUSH_PENDING;
        end
      end
      FLUSH_PENDING: begin
        if (skid_ready) begin
          flush_d = FLUSH_IDLE;
        end
      end
      default: flush_d = FLUSH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q   <= FLUSH_IDLE;
      batch_cnt <= '0;
    end else begin
      flush_q <= flush_d;
      if (beat_enq) begin
        batch_cnt <= beat_last ? '0 : batch_cnt + 1'b1;
      end else if (nop_enq) begin
        batch_cnt <= '0;
      end
    end
  end

  stream_skid_buffer #(
    .W (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_ready),
    .in_data   (skid_in_data),
    .out_valid (stream.valid_o),
    .out_data  (out_beat),
    .out_ready (stream.ready_i),
    .state     (skid_state)
  );

  assign stream.data_o = out_beat[DATA_WIDTH-1:0];
  assign stream.last_o = out_beat[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count_o <= '0;
    end else if (stream.valid_o && stream.ready_i &&
                 (op_t'(out_beat[op_msb(DATA_WIDTH) -: OP_WIDTH]) != OP_NOP)) begin
      sent_count_o <= sent_count_o + 1'b1;
    end
  end

  assign dbg = '{flush: flush_q, skid: skid_state};

endmodule

// File: tb/tb_hash_request_tx.sv
// Scoreboard bench for hash_request_tx: commands push expected beats, the
// output monitor pops and compares them on every transfer.
module tb_hash_request_tx;
  import hash_stream_pkg::*;

  localparam int DW = 32;
  localparam int KW = 14;
  localparam int VW = 16;
  localparam int MB = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] sent_count;
  dbg_t          dbg;

  hash_cmd_if    #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) cmd ();
  hash_stream_if #(.DATA_WIDTH(DW))                  stream ();

  hash_request_tx #(
    .DATA_WIDTH (DW),
    .KEY_WIDTH  (KW),
    .VALUE_WIDTH(VW),
    .MAX_BATCH  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd),
    .stream      (stream),
    .sent_count_o(sent_count),
    .dbg         (dbg)
  );

  always #5 clk = ~clk;

  logic [DW:0]   exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            tb_batch = 0;
  logic [CW-1:0] tb_sent = '0;
  bit            rand_ready = 1'b0;
  int            accept_cycles = 0;

  // Output monitor: a beat transfers on the next rising edge when valid && ready now.
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (!reset && stream.valid_o && stream.ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got data=%h last=%b, required no beat",
                 stream.data_o, stream.last_o);
      end else begin
        exp = exp_q.pop_front();
        if ({stream.last_o, stream.data_o} !== exp) begin
          fails++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   stream.data_o, stream.last_o, exp[DW-1:0], exp[DW]);
        end
        if (exp[DW-1 -: 2] != 2'b00) tb_sent++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack(input logic [1:0] op, input logic [KW-1:0] key,
                                         input logic [VW-1:0] value);
    return {op, (op == 2'b10) ? value : {VW{1'b0}}, key};
  endfunction

  task automatic model_accept();
    logic l;
    if (cmd.cmd_op_i != 2'b00) begin
      l = cmd.cmd_last_i || cmd.flush_i || (tb_batch == MB - 1);
      exp_q.push_back({l, pack(cmd.cmd_op_i, cmd.cmd_key_i, cmd.cmd_value_i)});
      tb_batch = l ? 0 : tb_batch + 1;
    end else if ((cmd.cmd_last_i || cmd.flush_i) && tb_batch != 0) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
      tb_batch = 0;
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [KW-1:0] key,
                           input logic [VW-1:0] value, input logic last, input logic flush);
    cmd.cmd_valid_i = 1'b1;
    cmd.cmd_op_i    = op;
    cmd.cmd_key_i   = key;
    cmd.cmd_value_i = value;
    cmd.cmd_last_i  = last;
    cmd.flush_i     = flush;
  endtask

  task automatic wait_accept();
    bit acc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = cmd.cmd_ready_o;
      step();
      accept_cycles++;
      if (acc) begin
        model_accept();
        cmd.cmd_valid_i = 1'b0;
        cmd.cmd_last_i  = 1'b0;
        cmd.flush_i     = 1'b0;
        return;
      end
      if (rand_ready) stream.ready_i = 1'($urandom_range(0, 1));
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: got cmd_ready_o=0 for 200 cycles, required a handshake");
    cmd.cmd_valid_i = 1'b0;
    cmd.flush_i     = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [KW-1:0] key,
                          input logic [VW-1:0] value, input logic last, input logic flush);
    drive_cmd(op, key, value, last, flush);
    wait_accept();
  endtask

  task automatic do_flush();
    cmd.flush_i = 1'b1;
    step();
    cmd.flush_i = 1'b0;
    if (tb_batch != 0) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
      tb_batch = 0;
    end
  endtask

  task automatic drain_and_check_count(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !stream.valid_o) break;
      step();
    end
    step();
    step();
    tests++;
    if (exp_q.size() != 0 || stream.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: got %0d beats outstanding valid_o=%b, required 0 and 0",
               name, exp_q.size(), stream.valid_o);
    end
    tests++;
    if (sent_count !== tb_sent) begin
      fails++;
      $display("FAIL %s_sent_count: got %0d, required %0d", name, sent_count, tb_sent);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stream.ready_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests += 6;
    if (stream.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", stream.valid_o); end
    if (stream.last_o !== 1'b0) begin fails++; $display("FAIL reset_last: got %b, required 0", stream.last_o); end
    if (stream.data_o !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", stream.data_o); end
    if (sent_count !== '0) begin fails++; $display("FAIL reset_sent: got %0d, required 0", sent_count); end
    if (cmd.cmd_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, required 0", cmd.cmd_ready_o); end
    if (dbg.skid !== EMPTY) begin fails++; $display("FAIL reset_skid_state: got %0d, required EMPTY", dbg.skid); end
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (cmd.cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b, required 1", cmd.cmd_ready_o);
    end
    step();
  endtask

  task automatic test_read();
    stream.ready_i = 1'b1;
    send_cmd(2'b01, 14'h0005, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (stream.valid_o !== 1'b1 || stream.data_o !== 32'h4000_0005 || stream.last_o !== 1'b0) begin
      fails++;
      $display("FAIL read_latency: got valid=%b data=%h last=%b, required 1 40000005 0",
               stream.valid_o, stream.data_o, stream.last_o);
    end
    step();
    drain_and_check_count("read");
  endtask

  task automatic test_write_last();
    send_cmd(2'b10, 14'h0003, 16'hABCD, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (stream.data_o !== 32'hAAF3_4003 || stream.last_o !== 1'b1) begin
      fails++;
      $display("FAIL write_last: got data=%h last=%b, required aaf34003 1",
               stream.data_o, stream.last_o);
    end
    step();
    drain_and_check_count("write_last");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    stream.ready_i = 1'b0;
    send_cmd(2'b10, 14'h0011, 16'h1111, 1'b0, 1'b0);
    send_cmd(2'b01, 14'h0022, 16'h2222, 1'b0, 1'b0);
    held = exp_q[0][DW-1:0];
    drive_cmd(2'b11, 14'h0033, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (cmd.cmd_ready_o !== 1'b0 || stream.valid_o !== 1'b1 || stream.data_o !== held) begin
        fails++;
        $display("FAIL backpressure_hold: got ready=%b valid=%b data=%h, required 0 1 %h",
                 cmd.cmd_ready_o, stream.valid_o, stream.data_o, held);
      end
      step();
    end
    tests++;
    if (dbg.skid !== TWO) begin
      fails++;
      $display("FAIL backpressure_state: got %0d, required TWO", dbg.skid);
    end
    stream.ready_i = 1'b1;
    wait_accept();
    drain_and_check_count("backpressure");
  endtask

  task automatic test_flush_after_reads();
    for (int i = 0; i < 3; i++) send_cmd(2'b01, 14'(i + 8), 16'h0, 1'b0, 1'b0);
    do_flush();
    drain_and_check_count("flush_after_reads");
    send_cmd(2'b01, 14'h0100, 16'h0, 1'b0, 1'b0);
    send_cmd(2'b00, 14'h0000, 16'h0, 1'b1, 1'b0);
    drain_and_check_count("nop_last_flush");
  endtask

  task automatic test_flush_with_write();
    send_cmd(2'b01, 14'h0042, 16'h0, 1'b0, 1'b0);
    send_cmd(2'b10, 14'h0043, 16'h5A5A, 1'b0, 1'b1);
    drain_and_check_count("flush_with_write");
    tests++;
    if (dbg.flush !== FLUSH_IDLE) begin
      fails++;
      $display("FAIL flush_with_write_state: got %0d, required FLUSH_IDLE", dbg.flush);
    end
  endtask

  task automatic test_flush_empty();
    do_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (stream.valid_o !== 1'b0) begin
        fails++;
        $display("FAIL flush_empty: got valid_o=%b, required 0", stream.valid_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    accept_cycles = 0;
    for (int i = 0; i < MB + 1; i++) send_cmd(2'b11, 14'(i), 16'hFFFF, 1'b0, 1'b0);
    tests++;
    if (accept_cycles != MB + 1) begin
      fails++;
      $display("FAIL back_to_back_throughput: got %0d cycles, required %0d", accept_cycles, MB + 1);
    end
    do_flush();
    drain_and_check_count("back_to_back");
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_cmd(2'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)),
               16'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0), 1'b0);
    end
    rand_ready = 1'b0;
    stream.ready_i = 1'b1;
    drain_and_check_count("random");
  endtask

  task automatic test_reset_in_two();
    stream.ready_i = 1'b0;
    send_cmd(2'b01, 14'h0061, 16'h0, 1'b0, 1'b0);
    send_cmd(2'b01, 14'h0062, 16'h0, 1'b0, 1'b0);
    tests++;
    if (dbg.skid !== TWO) begin
      fails++;
      $display("FAIL reset_two_state: got %0d, required TWO", dbg.skid);
    end
    reset = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (stream.valid_o !== 1'b0 || sent_count !== '0) begin
      fails++;
      $display("FAIL reset_two_drop: got valid=%b sent=%0d, required 0 0", stream.valid_o, sent_count);
    end
    exp_q.delete();
    tb_batch = 0;
    tb_sent  = '0;
    step();
    reset = 1'b0;
    stream.ready_i = 1'b1;
    send_cmd(2'b01, 14'h0007, 16'h0, 1'b0, 1'b0);
    drain_and_check_count("reset_two_resume");
  endtask

  initial begin
    cmd.cmd_valid_i = 1'b0;
    cmd.cmd_op_i    = 2'b00;
    cmd.cmd_key_i   = '0;
    cmd.cmd_value_i = '0;
    cmd.cmd_last_i  = 1'b0;
    cmd.flush_i     = 1'b0;
    stream.ready_i  = 1'b0;
    step();
    test_reset();
    test_read();
    test_write_last();
    test_backpressure();
    test_flush_after_reads();
    test_flush_with_write();
    test_flush_empty();
    test_back_to_back();
    test_random();
    test_reset_in_two();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
